// File: rtl/spi_dac_tx.sv
// SPI transmitter for a 10-bit DAC.
// Each accepted sample is sent as one 16-bit SPI mode-0 frame:
// {CFG_BITS, sample_data, 2'b00}, MSB first.
// The frame is framed by cs_n. sclk idles low, and mosi changes only on the
// sclk falling edge.
// Every output is a register, so no input reaches an output combinationally.
module spi_dac_tx #(
  parameter int unsigned CLK_DIV  = 2,
  parameter logic [3:0]  CFG_BITS = 4'b0011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [9:0] sample_data,
  output logic       sample_ready,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       busy,
  output logic       frame_done
);

  // Every phase (setup, sclk high, sclk low, hold) lasts CLK_DIV cycles.
  // The phase counter is loaded with CLK_DIV-1 and the phase ends when it
  // reaches zero.
  localparam logic [7:0] PHASE_RELOAD = 8'(CLK_DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]  state;
  logic [7:0]  phase_cnt;
  logic [3:0]  bit_cnt;
  logic [14:0] shift_reg;
  logic [15:0] frame_word;
  logic        accept;
  logic        phase_end;

  // Bit 15 goes straight to mosi when a sample is accepted. The shift register
  // only holds the 15 bits that follow it.
  assign frame_word = {CFG_BITS, sample_data, 2'b00};
  assign accept     = sample_valid && sample_ready;
  assign phase_end  = (phase_cnt == 8'd0);

  // Frame sequencer: IDLE -> SETUP -> SHIFT (16 bits) -> HOLD -> IDLE.
  // Reset aborts any frame immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase_cnt    <= 8'd0;
      bit_cnt      <= 4'd0;
      shift_reg    <= 15'd0;
      sample_ready <= 1'b0;
      sclk         <= 1'b0;
      mosi         <= 1'b0;
      cs_n         <= 1'b1;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= SETUP;
            shift_reg    <= frame_word[14:0];
            mosi         <= frame_word[15];
            cs_n         <= 1'b0;
            sclk         <= 1'b0;
            sample_ready <= 1'b0;
            busy         <= 1'b1;
            phase_cnt    <= PHASE_RELOAD;
            bit_cnt      <= 4'd15;
          end else begin
            sample_ready <= 1'b1;
          end
        end

        SETUP: begin
          if (phase_end) begin
            state     <= SHIFT;
            sclk      <= 1'b1;
            phase_cnt <= PHASE_RELOAD;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end

        SHIFT: begin
          if (!phase_end) begin
            phase_cnt <= phase_cnt - 8'd1;
          end else if (sclk) begin
            // At the end of the high phase, sclk falls and mosi moves on to
            // the next bit. The last bit stays on mosi until HOLD.
            sclk      <= 1'b0;
            phase_cnt <= PHASE_RELOAD;
            if (bit_cnt != 4'd0) begin
              mosi      <= shift_reg[14];
              shift_reg <= {shift_reg[13:0], 1'b0};
            end
          end else if (bit_cnt == 4'd0) begin
            state      <= HOLD;
            cs_n       <= 1'b1;
            mosi       <= 1'b0;
            frame_done <= 1'b1;
            phase_cnt  <= PHASE_RELOAD;
          end else begin
            bit_cnt   <= bit_cnt - 4'd1;
            sclk      <= 1'b1;
            phase_cnt <= PHASE_RELOAD;
          end
        end

        HOLD: begin
          if (phase_end) begin
            state        <= IDLE;
            sample_ready <= 1'b1;
            busy         <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end

        default: begin
          state        <= IDLE;
          sample_ready <= 1'b0;
          busy         <= 1'b0;
          cs_n         <= 1'b1;
          sclk         <= 1'b0;
          mosi         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_dac_tx.sv
// Testbench for spi_dac_tx.
// Three instances run side by side with CLK_DIV = 1, 2 and 3.
// A negedge monitor turns each instance's SPI pins back into frame records.
// The directed sequence checks those records against values computed from the
// frame format and the timing rules.
module tb_spi_dac_tx;

  localparam logic [3:0] CFG = 4'b0011;

  typedef struct {
    int          dut;
    logic [15:0] word;
    int          bits;
    int          low_cycles;
    int          gap;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] valid_s = 3'b000;
  logic [2:0] ready_s, sclk_s, mosi_s, csn_s, busy_s, done_s;
  logic [9:0] data_s [3];

  int n_cmp = 0;
  int n_err = 0;

  frame_t      frames[$];
  int          done_cnt [3] = '{default: 0};
  int          low_cnt  [3] = '{default: 0};
  int          hi_cnt   [3] = '{default: 0};
  int          bit_seen [3] = '{default: 0};
  int          gap_start[3] = '{default: 0};
  logic [15:0] word_acc [3] = '{default: 16'h0};
  logic [2:0]  prev_cs   = 3'b111;
  logic [2:0]  prev_sclk = 3'b000;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      spi_dac_tx #(.CLK_DIV(g + 1), .CFG_BITS(CFG)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (valid_s[g]),
        .sample_data  (data_s[g]),
        .sample_ready (ready_s[g]),
        .sclk         (sclk_s[g]),
        .mosi         (mosi_s[g]),
        .cs_n         (csn_s[g]),
        .busy         (busy_s[g]),
        .frame_done   (done_s[g])
      );
    end
  endgenerate

  // SPI monitor: acts as the DAC side of each bus and records every cs_n-low window.
  always @(negedge clk) begin : mon
    frame_t f;
    for (int i = 0; i < 3; i++) begin
      if (done_s[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
      if (csn_s[i] === 1'b0) begin
        if (prev_cs[i] !== 1'b0) begin
          word_acc[i]  <= 16'h0;
          bit_seen[i]  <= 0;
          low_cnt[i]   <= 1;
          gap_start[i] <= hi_cnt[i];
        end else begin
          low_cnt[i] <= low_cnt[i] + 1;
        end
        if (sclk_s[i] === 1'b1 && prev_sclk[i] !== 1'b1) begin
          word_acc[i] <= {word_acc[i][14:0], mosi_s[i]};
          bit_seen[i] <= bit_seen[i] + 1;
        end
      end else begin
        if (prev_cs[i] === 1'b0) begin
          f.dut        = i;
          f.word       = word_acc[i];
          f.bits       = bit_seen[i];
          f.low_cycles = low_cnt[i];
          f.gap        = gap_start[i];
          frames.push_back(f);
          hi_cnt[i] <= 1;
        end else begin
          hi_cnt[i] <= hi_cnt[i] + 1;
        end
      end
      prev_cs[i]   <= csn_s[i];
      prev_sclk[i] <= sclk_s[i];
    end
  end

  // A stuck design must never hang the run.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_frame(output frame_t f, output bit ok);
    ok = (frames.size() != 0);
    check_output("frame_present", 32'(ok), 32'd1);
    if (ok) f = frames.pop_front();
  endtask

  // Reset with sample_valid high: nothing may be accepted, and ready rises
  // one edge after release.
  task automatic apply_reset();
    @(negedge clk);
    rst     = 1'b1;
    valid_s = 3'b111;
    for (int i = 0; i < 3; i++) data_s[i] = 10'($urandom);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_output("rst_ready", 32'(ready_s[i]), 32'd0);
      check_output("rst_cs_n",  32'(csn_s[i]),   32'd1);
      check_output("rst_sclk",  32'(sclk_s[i]),  32'd0);
      check_output("rst_mosi",  32'(mosi_s[i]),  32'd0);
      check_output("rst_busy",  32'(busy_s[i]),  32'd0);
      check_output("rst_done",  32'(done_s[i]),  32'd0);
    end
    @(negedge clk);
    rst     = 1'b0;
    valid_s = 3'b000;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_output("post_rst_ready", 32'(ready_s[i]), 32'd1);
      check_output("post_rst_cs_n",  32'(csn_s[i]),   32'd1);
    end
  endtask

  // Send one sample on instance d. With noise set, random valid and data
  // pulses are driven while the instance is busy.
  task automatic apply_stimulus(input int d, input logic [9:0] val, input bit noise);
    int     n;
    int     dn0;
    int     div;
    frame_t f;
    bit     ok;
    div = d + 1;
    @(negedge clk);
    check_output("ready_before_accept", 32'(ready_s[d]), 32'd1);
    dn0        = done_cnt[d];
    valid_s[d] = 1'b1;
    data_s[d]  = val;
    @(posedge clk);
    #1;
    valid_s[d] = 1'b0;
    data_s[d]  = 10'($urandom);
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (ready_s[d] === 1'b1) break;
      valid_s[d] = noise ? 1'($urandom) : 1'b0;
      data_s[d]  = 10'($urandom);
    end
    valid_s[d] = 1'b0;
    check_output("next_accept_edge", 32'(n + 1), 32'(34 * div + 1));
    @(negedge clk);
    pop_frame(f, ok);
    if (ok) begin
      check_output("frame_dut",     32'(f.dut),        32'(d));
      check_output("frame_word",    32'(f.word),       32'({CFG, val, 2'b00}));
      check_output("frame_bits",    32'(f.bits),       32'd16);
      check_output("cs_low_cycles", 32'(f.low_cycles), 32'(33 * div));
    end
    check_output("frame_done_pulses", 32'(done_cnt[d] - dn0), 32'd1);
    check_output("no_extra_frame",    32'(frames.size()),     32'd0);
  endtask

  logic [9:0] rnd;
  logic [9:0] base;
  logic [9:0] tmp;
  int         bad;
  int         dn0;
  int         exp_bits;
  logic [15:0] exp_word;
  frame_t     fr;
  bit         ok;

  initial begin
    for (int i = 0; i < 3; i++) data_s[i] = 10'h0;
    $display("[TB] start");
    apply_reset();

    // Idle for 100 cycles with no valid.
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (!(csn_s[i] === 1'b1 && sclk_s[i] === 1'b0 && busy_s[i] === 1'b0 && ready_s[i] === 1'b1))
          bad++;
    end
    check_output("idle_bad_cycles", 32'(bad), 32'd0);

    // Directed frames at CLK_DIV=2, then frames with stray valid pulses while busy.
    apply_stimulus(1, 10'h2AA, 1'b0);
    apply_stimulus(1, 10'h3FF, 1'b0);
    for (int k = 0; k < 2; k++) begin
      rnd = 10'($urandom);
      apply_stimulus(1, rnd, 1'b1);
    end

    // Random frames on every divider.
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 2; k++) begin
        rnd = 10'($urandom);
        apply_stimulus(d, rnd, 1'($urandom));
      end
    end

    // CLK_DIV=1 with valid held high and data counting every clock.
    // Frames start every 35 edges and carry the data present at those edges.
    base = 10'($urandom);
    dn0  = done_cnt[0];
    @(negedge clk);
    check_output("b2b_ready_start", 32'(ready_s[0]), 32'd1);
    for (int c = 0; c < 106; c++) begin
      data_s[0]  = base + 10'(c);
      valid_s[0] = (c < 105);
      @(negedge clk);
    end
    valid_s[0] = 1'b0;
    check_output("b2b_ready_end", 32'(ready_s[0]), 32'd1);
    check_output("b2b_busy_end",  32'(busy_s[0]),  32'd0);
    for (int k = 0; k < 3; k++) begin
      pop_frame(fr, ok);
      if (ok) begin
        tmp = base + 10'(35 * k);
        check_output("b2b_word", 32'(fr.word),       32'({CFG, tmp, 2'b00}));
        check_output("b2b_low",  32'(fr.low_cycles), 32'd33);
        if (k > 0) check_output("b2b_cs_high_gap", 32'(fr.gap), 32'd2);
      end
    end
    check_output("b2b_done_pulses", 32'(done_cnt[0] - dn0), 32'd3);
    check_output("b2b_no_extra",    32'(frames.size()),     32'd0);

    // CLK_DIV=3: reset lands during the high phase of bit 7.
    // Nine sclk rising edges (bits 15..7) have been seen by then.
    rnd      = 10'($urandom);
    exp_word = {CFG, rnd, 2'b00};
    exp_bits = (52 - 3) / 6 + 1;
    dn0      = done_cnt[2];
    @(negedge clk);
    check_output("abort_ready_before", 32'(ready_s[2]), 32'd1);
    valid_s[2] = 1'b1;
    data_s[2]  = rnd;
    @(posedge clk);
    #1;
    valid_s[2] = 1'b0;
    repeat (52) @(posedge clk);
    #1;
    check_output("abort_busy_mid",  32'(busy_s[2]), 32'd1);
    check_output("abort_cs_n_mid",  32'(csn_s[2]),  32'd0);
    check_output("abort_sclk_mid",  32'(sclk_s[2]), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("abort_cs_n",  32'(csn_s[2]),   32'd1);
    check_output("abort_sclk",  32'(sclk_s[2]),  32'd0);
    check_output("abort_busy",  32'(busy_s[2]),  32'd0);
    check_output("abort_ready", 32'(ready_s[2]), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("abort_ready_after", 32'(ready_s[2]), 32'd1);
    check_output("abort_cs_n_after",  32'(csn_s[2]),   32'd1);
    repeat (20) @(posedge clk);
    #1;
    check_output("abort_no_done", 32'(done_cnt[2] - dn0), 32'd0);
    check_output("abort_no_resume", 32'(csn_s[2]), 32'd1);
    pop_frame(fr, ok);
    if (ok) begin
      check_output("abort_bits", 32'(fr.bits), 32'(exp_bits));
      check_output("abort_partial_word", 32'(fr.word[8:0]), 32'(exp_word[15:7]));
    end
    check_output("abort_no_extra", 32'(frames.size()), 32'd0);

    // A normal frame still goes out after the abort.
    rnd = 10'($urandom);
    apply_stimulus(2, rnd, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
